// File: rtl/onchip_mem_bist_master_if.sv
// Avalon-MM bus between the BIST master and the single-port on-chip RAM slave (s1).
interface onchip_mem_bist_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic                mem_reset_req;
  logic [DATA_W-1:0]   mem_readdata;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken, mem_reset_req,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
           mem_writedata, mem_clken, mem_reset_req,
    output mem_readdata
  );
endinterface

// File: rtl/onchip_mem_bist_master.sv
// Memory self-test master: fills the RAM with a pattern, reads it back, and
// reports pass/fail, first failing location and a saturating error count.
module onchip_mem_bist_master #(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 pattern_sel,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_count,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic [DATA_W-1:0]          fail_data,
  output logic [DATA_W-1:0]          fail_expected,
  onchip_mem_bist_master_if.master   mem
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;

  logic [2:0]        state;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       lfsr;
  logic              cs_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;

  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       lfsr_next;
  logic [DATA_W-1:0] cur_pat;
  logic [DATA_W-1:0] nxt_pat;
  logic              mismatch;
  logic              first_err;
  logic [15:0]       err_next;

  // Galois form of x^32+x^22+x^2+x+1, shifting right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] s,
                                                input logic [ADDR_W-1:0] k,
                                                input logic [31:0] l);
    case (s)
      2'd0:    return DATA_W'(k);
      2'd1:    return ~DATA_W'(k);
      2'd2:    return k[0] ? {(DATA_W/8){8'h5A}} : {(DATA_W/8){8'hA5}};
      default: return DATA_W'(l);
    endcase
  endfunction

  always_comb begin
    addr_next = addr + ADDR_W'(1);
    lfsr_next = lfsr_step(lfsr);
    cur_pat   = pattern(sel, addr, lfsr);
    nxt_pat   = pattern(sel, addr_next, lfsr_next);
    mismatch  = cmp_valid && (mem.mem_readdata != cmp_exp);
    first_err = mismatch && (err_count == '0);
    err_next  = err_count;
    if (mismatch && (err_count != 16'hFFFF))
      err_next = err_count + 16'd1;
  end

  // Read compare runs one cycle behind the issued address to match RAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      sel           <= '0;
      addr          <= '0;
      lfsr          <= LFSR_SEED;
      cs_q          <= 1'b0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      cmp_valid     <= 1'b0;
      cmp_addr      <= '0;
      cmp_exp       <= '0;
      pass          <= 1'b0;
      err_count     <= '0;
      fail_addr     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
    end else begin
      cmp_valid <= (state == S_READ);
      cmp_addr  <= addr;
      cmp_exp   <= cur_pat;
      err_count <= err_next;
      if (first_err) begin
        fail_addr     <= cmp_addr;
        fail_data     <= mem.mem_readdata;
        fail_expected <= cmp_exp;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            sel           <= pattern_sel;
            err_count     <= '0;
            fail_addr     <= '0;
            fail_data     <= '0;
            fail_expected <= '0;
            pass          <= 1'b0;
            addr          <= '0;
            lfsr          <= LFSR_SEED;
            cs_q          <= 1'b1;
            wr_q          <= 1'b1;
            wdata_q       <= pattern(pattern_sel, '0, LFSR_SEED);
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (addr == LAST_ADDR) begin
            addr  <= '0;
            lfsr  <= LFSR_SEED;
            wr_q  <= 1'b0;
            state <= S_READ;
          end else begin
            addr    <= addr_next;
            lfsr    <= lfsr_next;
            wdata_q <= nxt_pat;
          end
        end
        S_READ: begin
          if (addr == LAST_ADDR) begin
            cs_q  <= 1'b0;
            state <= S_DRAIN;
          end else begin
            addr <= addr_next;
            lfsr <= lfsr_next;
          end
        end
        S_DRAIN: begin
          pass  <= (err_next == '0);
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign mem.mem_address    = addr;
  assign mem.mem_chipselect = cs_q;
  assign mem.mem_write      = wr_q;
  assign mem.mem_writedata  = wdata_q;
  assign mem.mem_byteenable = '1;
  assign mem.mem_clken      = 1'b1;
  assign mem.mem_reset_req  = 1'b0;

endmodule

// File: tb/tb_onchip_mem_bist_master.sv
// Scoreboard bench for onchip_mem_bist_master with a 1-cycle-latency RAM model
// that can inject stuck bits, flipped bits or constant-zero reads.
module tb_onchip_mem_bist_master;
  localparam int          ADDR_W = 10;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] SEED   = 32'hACE1_2468;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        pattern_sel;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data, fail_expected;

  int checks = 0;
  int errors = 0;

  onchip_mem_bist_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_mem_bist_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LFSR_SEED(SEED)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .pattern_sel(pattern_sel),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_expected(fail_expected),
    .mem(bus)
  );

  always #5 clk = ~clk;

  // RAM model with fault injection
  logic [31:0] ram      [DEPTH];
  logic [31:0] or_mask  [DEPTH];
  logic [31:0] xor_mask [DEPTH];
  logic        zero_reads;

  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write)
        ram[bus.mem_address] <= bus.mem_writedata;
      else
        bus.mem_readdata <= zero_reads ? 32'h0 :
          ((ram[bus.mem_address] | or_mask[bus.mem_address]) ^ xor_mask[bus.mem_address]);
    end
  end

  // Scoreboard of expected bus transactions
  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } txn_t;
  txn_t sb[$];
  txn_t mon_t;

  always @(negedge clk) begin
    if (!reset && bus.mem_chipselect) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bus_txn: got wr=%0b addr=%0d data=%h, required no transaction",
                 bus.mem_write, bus.mem_address, bus.mem_writedata);
      end else begin
        mon_t = sb.pop_front();
        if (bus.mem_write !== mon_t.wr || bus.mem_address !== mon_t.addr ||
            bus.mem_byteenable !== 4'hF ||
            (mon_t.wr && bus.mem_writedata !== mon_t.data)) begin
          errors++;
          $display("FAIL bus_txn: got wr=%0b addr=%0d data=%h be=%h, required wr=%0b addr=%0d data=%h be=f",
                   bus.mem_write, bus.mem_address, bus.mem_writedata, bus.mem_byteenable,
                   mon_t.wr, mon_t.addr, mon_t.data);
        end
      end
    end
  end

  function automatic logic [31:0] exp_pat(input logic [1:0] s, input int k, input logic [31:0] l);
    case (s)
      2'd0:    return 32'(k);
      2'd1:    return ~32'(k);
      2'd2:    return (k % 2 == 1) ? 32'h5A5A_5A5A : 32'hA5A5_A5A5;
      default: return l;
    endcase
  endfunction

  task automatic clear_faults();
    for (int k = 0; k < DEPTH; k++) begin
      or_mask[k]  = 32'h0;
      xor_mask[k] = 32'h0;
    end
    zero_reads = 1'b0;
  endtask

  // Loads the expected write/read stream and pulses start; returns in cycle 1.
  task automatic start_test(input logic [1:0] s);
    logic [31:0] l;
    txn_t t;
    sb.delete();
    l = SEED;
    for (int k = 0; k < DEPTH; k++) begin
      t.wr = 1'b1; t.addr = ADDR_W'(k); t.data = exp_pat(s, k, l);
      sb.push_back(t);
      l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    end
    for (int k = 0; k < DEPTH; k++) begin
      t.wr = 1'b0; t.addr = ADDR_W'(k); t.data = 32'h0;
      sb.push_back(t);
    end
    @(posedge clk); #1 pattern_sel = s; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; pattern_sel = s ^ 2'b11;
  endtask

  task automatic wait_done(input int first, output int cyc);
    cyc = -1;
    for (int c = first; c <= 3 * DEPTH; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/done/pass=%b, required 000", {busy, done, pass});
    end
    checks++;
    if (err_count !== 16'h0) begin
      errors++; $display("FAIL reset_err_count: got %h, required 0000", err_count);
    end
    checks++;
    if (fail_addr !== '0 || fail_data !== '0 || fail_expected !== '0) begin
      errors++; $display("FAIL reset_fail_regs: got %0d %h %h, required 0 0 0", fail_addr, fail_data, fail_expected);
    end
    checks++;
    if ({bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_writedata} !== '0) begin
      errors++; $display("FAIL reset_bus: got cs=%b wr=%b addr=%0d wd=%h, required all 0",
                         bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_writedata);
    end
    checks++;
    if ({bus.mem_byteenable, bus.mem_clken, bus.mem_reset_req} !== {4'hF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_constants: got be=%h clken=%b reset_req=%b, required f 1 0",
                         bus.mem_byteenable, bus.mem_clken, bus.mem_reset_req);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_pattern0();
    int cyc;
    clear_faults();
    start_test(2'd0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.mem_write !== 1'b1 || bus.mem_address !== '0) begin
      errors++; $display("FAIL p0_cycle1: got busy=%b wr=%b addr=%0d, required 1 1 0", busy, bus.mem_write, bus.mem_address);
    end
    wait_done(2, cyc);
    checks++;
    if (cyc !== 2 * DEPTH + 2) begin
      errors++; $display("FAIL p0_done_cycle: got %0d, required %0d", cyc, 2 * DEPTH + 2);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL p0_result: got pass=%b err=%0d busy=%b, required 1 0 0", pass, err_count, busy);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL p0_all_txns: got %0d left, required 0", sb.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      errors++; $display("FAIL p0_done_pulse: got done=%b pass=%b, required 0 1", done, pass);
    end
  endtask

  task automatic test_pattern3();
    int cyc;
    clear_faults();
    start_test(2'd3);
    @(negedge clk);
    checks++;
    if (bus.mem_writedata !== 32'hACE1_2468) begin
      errors++; $display("FAIL p3_first_word: got %h, required ace12468", bus.mem_writedata);
    end
    wait_done(2, cyc);
    checks++;
    if (cyc !== 2 * DEPTH + 2 || pass !== 1'b1 || err_count !== 16'h0) begin
      errors++; $display("FAIL p3_result: got cyc=%0d pass=%b err=%0d, required %0d 1 0", cyc, pass, err_count, 2 * DEPTH + 2);
    end
  endtask

  task automatic test_stuck_bit();
    int cyc;
    clear_faults();
    or_mask[5] = 32'h1;
    start_test(2'd2);
    @(negedge clk);
    checks++;
    if (pass !== 1'b0) begin
      errors++; $display("FAIL stuck_pass_cleared: got %b, required 0", pass);
    end
    wait_done(2, cyc);
    checks++;
    if (err_count !== 16'd1 || fail_addr !== 10'd5 || pass !== 1'b0) begin
      errors++; $display("FAIL stuck_result: got err=%0d addr=%0d pass=%b, required 1 5 0", err_count, fail_addr, pass);
    end
    checks++;
    if (fail_expected !== 32'h5A5A_5A5A || fail_data !== 32'h5A5A_5A5B) begin
      errors++; $display("FAIL stuck_data: got exp=%h data=%h, required 5a5a5a5a 5a5a5a5b", fail_expected, fail_data);
    end
  endtask

  task automatic test_two_corrupt();
    int cyc;
    clear_faults();
    xor_mask[3]   = 32'h0000_0001;
    xor_mask[700] = 32'h0001_0000;
    start_test(2'd1);
    wait_done(1, cyc);
    checks++;
    if (err_count !== 16'd2 || fail_addr !== 10'd3 || pass !== 1'b0) begin
      errors++; $display("FAIL two_result: got err=%0d addr=%0d pass=%b, required 2 3 0", err_count, fail_addr, pass);
    end
    checks++;
    if (fail_expected !== 32'hFFFF_FFFC || fail_data !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL two_data: got exp=%h data=%h, required fffffffc fffffffd", fail_expected, fail_data);
    end
  endtask

  task automatic test_start_busy_reset();
    int cyc;
    logic found, saw_done;
    clear_faults();
    start_test(2'd0);
    repeat (8) @(posedge clk);
    #1 pattern_sel = 2'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2 * DEPTH && !found; c++) begin
      @(negedge clk);
      if (bus.mem_write && bus.mem_address == 10'd100) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL abort_reach_word100: got %b, required 1", found);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.mem_chipselect !== 1'b0 || bus.mem_write !== 1'b0 || pass !== 1'b0) begin
      errors++; $display("FAIL abort_after_reset: got busy=%b cs=%b wr=%b pass=%b, required 0 0 0 0",
                         busy, bus.mem_chipselect, bus.mem_write, pass);
    end
    saw_done = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got done/busy seen=%b, required 0", saw_done);
    end
    start_test(2'd0);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 2 * DEPTH + 2 || pass !== 1'b1 || err_count !== 16'h0) begin
      errors++; $display("FAIL abort_rerun: got cyc=%0d pass=%b err=%0d, required %0d 1 0", cyc, pass, err_count, 2 * DEPTH + 2);
    end
  endtask

  task automatic test_all_zero();
    int cyc;
    clear_faults();
    zero_reads = 1'b1;
    start_test(2'd2);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 2 * DEPTH + 2 || err_count !== 16'd1024 || fail_addr !== '0) begin
      errors++; $display("FAIL zero_result: got cyc=%0d err=%0d addr=%0d, required %0d 1024 0", cyc, err_count, fail_addr, 2 * DEPTH + 2);
    end
    checks++;
    if (fail_data !== 32'h0 || fail_expected !== 32'hA5A5_A5A5 || pass !== 1'b0) begin
      errors++; $display("FAIL zero_data: got data=%h exp=%h pass=%b, required 0 a5a5a5a5 0", fail_data, fail_expected, pass);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err_count !== 16'd1024 || busy !== 1'b0 || bus.mem_chipselect !== 1'b0) begin
      errors++; $display("FAIL zero_hold: got err=%0d busy=%b cs=%b, required 1024 0 0", err_count, busy, bus.mem_chipselect);
    end
  endtask

  initial begin
    clear_faults();
    test_reset();
    test_pattern0();
    test_pattern3();
    test_stuck_bit();
    test_two_corrupt();
    test_start_busy_reset();
    test_all_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/onchip_mem_bist_master.md
Name: onchip_mem_bist_master

Overview:
- Avalon-MM master that sits directly upstream of the 32-bit x 1024-word single-port on-chip RAM slave (s1) and drives its address, write and byteenable inputs.
- On start it fills the whole RAM with a selected pattern, reads every word back and compares it against the regenerated pattern.
- It reports pass/fail, the first failing location and a saturating error count.
- Used as a power-on / on-demand memory self-test in the CPU test system.

Parameters:
ADDR_W, 10, RAM word-address width
DATA_W, 32, RAM data width (multiple of 8)
DEPTH, 1024, number of words tested (≤ 2**ADDR_W)
LFSR_SEED, 32'hACE1_2468, non-zero seed for pattern 3

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
pattern_sel  in  2  0=address, 1=~address, 2=checkerboard, 3=LFSR
busy  out  1  high from first cycle after accepted start until done
done  out  1  one-cycle pulse at end of test
pass  out  1  result of last completed test, held until next accepted start
err_count  out  16  mismatching words, saturates at 16'hFFFF
fail_addr  out  ADDR_W  address of first mismatch
fail_data  out  DATA_W  read data at first mismatch
fail_expected  out  DATA_W  expected data at first mismatch
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  DATA_W/8  to RAM byteenable; constant all-ones
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken; constant 1
mem_reset_req  out  1  to RAM reset_req; constant 0
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Reset values:
  - state=IDLE; busy=0, done=0, pass=0, err_count=0.
  - fail_addr=0, fail_data=0, fail_expected=0.
  - mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0.
- All mem_* outputs except the constants are registered.
- RAM read latency is exactly 1: data for the address presented in cycle N is valid on mem_readdata in cycle N+1.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches pattern_sel and clears err_count, fail_*, pass.
  - Resets the address counter and the LFSR to LFSR_SEED, then moves to WRITE.
  - start is ignored in every other state.
- WRITE, one word per cycle:
  - Drives chipselect=1, write=1, address=k, writedata=P(k) for k=0..DEPTH-1.
  - After k=DEPTH-1, goes to READ with the counter and LFSR reloaded.
- READ, one word per cycle:
  - Drives chipselect=1, write=0, address=k for k=0..DEPTH-1.
  - Expected value and address are delayed one cycle to line up with mem_readdata.
  - Compare happens in the cycle after each issue.
- DRAIN: chipselect=0; performs the compare for k=DEPTH-1.
- DONE: done=1 for one cycle, busy drops, pass=(err_count==0); returns to IDLE.
- Timing: if start is sampled at edge E0, the first write is on the bus in cycle 1 and done is high in cycle 2*DEPTH+2.
  - busy is high in cycles 1..2*DEPTH+1.
- Patterns P(k), zero-extended to DATA_W:
  - 0: k.
  - 1: bitwise NOT of zero-extended k.
  - 2: {DATA_W/8{8'hA5}} when k even, {DATA_W/8{8'h5A}} when k odd.
  - 3: LFSR value. Galois x^32+x^22+x^2+x+1, advanced once per word. Word 0 is LFSR_SEED. The read phase regenerates the identical sequence.
- Mismatch handling:
  - On the first mismatch, capture fail_addr/fail_data/fail_expected; later mismatches do not overwrite them.
  - err_count increments on every mismatch and saturates at FFFF.
- Reset mid-test: the next cycle is IDLE with chipselect=0 and write=0; no done pulse; pass=0.
- k wraps only via state change; the address never exceeds DEPTH-1.

Test Plan:
- Pattern 0, fault-free RAM model, start pulse -> 1024 writes with writedata==address, then 1024 reads; done at cycle 2050; pass=1, err_count=0.
- Pattern 3 -> first write data 32'hACE1_2468; read phase expected sequence matches write sequence; pass=1.
- Pattern 2 with a RAM model forcing bit 0 of word 5 stuck at 1 -> err_count=1, fail_addr=5, fail_expected=32'h5A5A5A5A, fail_data=32'h5A5A5A5B, pass=0.
- Pattern 1 with word 3 and word 700 corrupted -> err_count=2, fail_addr=3 (first kept), pass=0.
- Start asserted during busy, then reset asserted at write word 100 -> extra start ignored; after reset, busy=0 and chipselect=0 next cycle, no done; a new start runs a full test to pass=1.
- Model returning constant 0 for all reads with pattern 2 -> err_count=1024, fail_addr=0; DEPTH=16 run gives done at cycle 34.
